// File: rtl/lcd_port_arbiter.sv
// Two-requester round-robin arbiter in front of an LCD byte controller.
// A grant is followed by a start pulse, a wait for done (with timeout), then an optional settle delay.
module lcd_port_arbiter #(
  parameter logic [17:0] POST_DELAY   = 18'd262143,
  parameter logic [19:0] DONE_TIMEOUT = 20'd1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [8:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [8:0] req1_data,
  output logic       req1_ready,
  output logic       lcd_start,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  input  logic       lcd_done,
  output logic       busy,
  output logic       grant_id,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DLY
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic        terr_q, terr_d;
  logic [19:0] wcnt_q, wcnt_d;
  logic [17:0] dcnt_q, dcnt_d;

  logic        grant_sel;
  logic        accept;
  logic        wait_hit;
  logic        dly_hit;

  // Ready is gated by rst so nothing is offered while reset is held.
  always_comb begin
    grant_sel = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    accept    = rst && (state_q == S_IDLE) && (req0_valid || req1_valid);
    wait_hit  = ({1'b0, wcnt_q} + 21'd1) >= {1'b0, DONE_TIMEOUT};
    dly_hit   = ({1'b0, dcnt_q} + 19'd1) >= {1'b0, POST_DELAY};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      rs_q    <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      terr_q  <= 1'b0;
      wcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      terr_q  <= terr_d;
      wcnt_q  <= wcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rs_d    = rs_q;
    grant_d = grant_q;
    last_d  = last_q;
    terr_d  = terr_q;
    wcnt_d  = wcnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          data_d  = grant_sel ? req1_data[7:0] : req0_data[7:0];
          rs_d    = grant_sel ? req1_data[8] : req0_data[8];
          grant_d = grant_sel;
          last_d  = grant_sel;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        wcnt_d  = '0;
      end
      S_WAIT: begin
        // Done wins over a simultaneous timeout, so the flag is only set without done.
        if (lcd_done || wait_hit) begin
          if (!lcd_done) terr_d = 1'b1;
          if (POST_DELAY == '0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DLY;
            dcnt_d  = '0;
          end
        end else begin
          wcnt_d = wcnt_q + 20'd1;
        end
      end
      S_DLY: begin
        if (dly_hit) begin
          state_d = S_IDLE;
        end else if (dcnt_q != '1) begin
          dcnt_d = dcnt_q + 18'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready  = accept && !grant_sel;
    req1_ready  = accept && grant_sel;
    lcd_start   = (state_q == S_START);
    busy        = (state_q != S_IDLE);
    lcd_data    = data_q;
    lcd_rs      = rs_q;
    grant_id    = grant_q;
    timeout_err = terr_q;
  end

endmodule

// File: tb/tb_lcd_port_arbiter.sv
// Directed bench: a per-cycle vector table on a POST_DELAY=4 / DONE_TIMEOUT=8 instance,
// plus hand sequences for timeout, reset mid-delay and a POST_DELAY=0 instance.
module tb_lcd_port_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: POST_DELAY=4, DONE_TIMEOUT=8
  logic       rst = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0, done = 1'b0;
  logic [8:0] d0 = '0, d1 = '0;
  logic       r0, r1, st, rs, busy, gid, terr;
  logic [7:0] data;

  lcd_port_arbiter #(.POST_DELAY(18'd4), .DONE_TIMEOUT(20'd8)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .lcd_start(st), .lcd_data(data), .lcd_rs(rs), .lcd_done(done),
    .busy(busy), .grant_id(gid), .timeout_err(terr)
  );

  // Instance B: POST_DELAY=0
  logic       b_rst = 1'b0;
  logic       b_v0 = 1'b0, b_done = 1'b0;
  logic [8:0] b_d0 = '0;
  logic       b_r0, b_r1, b_st, b_rs, b_busy, b_gid, b_terr;
  logic [7:0] b_data;

  lcd_port_arbiter #(.POST_DELAY(18'd0), .DONE_TIMEOUT(20'd8)) dut_b (
    .clk(clk), .rst(b_rst),
    .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
    .req1_valid(1'b0), .req1_data(9'h000), .req1_ready(b_r1),
    .lcd_start(b_st), .lcd_data(b_data), .lcd_rs(b_rs), .lcd_done(b_done),
    .busy(b_busy), .grant_id(b_gid), .timeout_err(b_terr)
  );

  typedef struct packed {
    logic        rst;
    logic        v0;
    logic [8:0]  d0;
    logic        v1;
    logic [8:0]  d1;
    logic        done;
    logic [14:0] exp;   // {r0, r1, start, data, rs, busy, gid, terr}
  } vec_t;

  vec_t tbl[$];
  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  function automatic logic [14:0] E(input logic er0, input logic er1, input logic est,
                                    input logic [7:0] ed, input logic ers, input logic eb,
                                    input logic eg, input logic et);
    return {er0, er1, est, ed, ers, eb, eg, et};
  endfunction

  task automatic add(input logic ar, input logic av0, input logic [8:0] ad0,
                     input logic av1, input logic [8:0] ad1, input logic adn,
                     input logic [14:0] ae);
    vec_t v;
    v.rst = ar; v.v0 = av0; v.d0 = ad0; v.v1 = av1; v.d1 = ad1; v.done = adn; v.exp = ae;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  function automatic logic [14:0] outs_a();
    return {r0, r1, st, data, rs, busy, gid, terr};
  endfunction

  task automatic drive(input logic av0, input logic [8:0] ad0,
                       input logic av1, input logic [8:0] ad1, input logic adn);
    @(negedge clk);
    v0 = av0; d0 = ad0; v1 = av1; d1 = ad1; done = adn;
    #1;
  endtask

  initial begin
    logic [7:0] pd, cd;
    logic       prs, crs, pg, g;

    // Single request 9'h038 from reset
    add(0, 1, 9'h038, 0, 9'h000, 0, E(0,0,0,8'h00,0,0,0,0));
    add(1, 1, 9'h038, 0, 9'h000, 0, E(1,0,0,8'h00,0,0,0,0));
    add(1, 0, 9'h000, 0, 9'h000, 0, E(0,0,1,8'h38,0,1,0,0));
    add(1, 0, 9'h000, 0, 9'h000, 0, E(0,0,0,8'h38,0,1,0,0));
    add(1, 0, 9'h000, 0, 9'h000, 1, E(0,0,0,8'h38,0,1,0,0));
    for (int k = 0; k < 4; k++)
      add(1, 0, 9'h000, 0, 9'h000, (k == 1 || k == 3), E(0,0,0,8'h38,0,1,0,0));
    add(1, 0, 9'h000, 0, 9'h000, 1, E(0,0,0,8'h38,0,0,0,0));
    add(1, 0, 9'h000, 0, 9'h000, 0, E(0,0,0,8'h38,0,0,0,0));

    // Tie from reset: req0 wins first, then alternate
    add(0, 1, 9'h001, 1, 9'h141, 0, E(0,0,0,8'h00,0,0,0,0));
    pd = 8'h00; prs = 1'b0; pg = 1'b0;
    for (int t = 0; t < 4; t++) begin
      g   = t[0];
      cd  = g ? 8'h41 : 8'h01;
      crs = g;
      add(1, 1, 9'h001, 1, 9'h141, 0, E(!g, g, 0, pd, prs, 0, pg, 0));
      add(1, 1, 9'h001, 1, 9'h141, 0, E(0,0,1, cd, crs, 1, g, 0));
      add(1, 1, 9'h001, 1, 9'h141, 1, E(0,0,0, cd, crs, 1, g, 0));
      for (int k = 0; k < 4; k++)
        add(1, (t != 3), 9'h001, (t != 3), 9'h141, 0, E(0,0,0, cd, crs, 1, g, 0));
      pd = cd; prs = crs; pg = g;
    end
    add(1, 0, 9'h001, 0, 9'h141, 0, E(0,0,0,8'h41,1,0,1,0));
    add(1, 0, 9'h001, 0, 9'h141, 0, E(0,0,0,8'h41,1,0,1,0));

    @(negedge clk);
    @(negedge clk);
    b_rst = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; v0 = tbl[i].v0; d0 = tbl[i].d0;
      v1 = tbl[i].v1; d1 = tbl[i].d1; done = tbl[i].done;
      #1;
      chk($sformatf("vec[%0d]", i), {17'd0, outs_a()}, {17'd0, tbl[i].exp});
    end

    // Done arriving in the last timeout cycle counts as done
    drive(1, 9'h0AA, 0, 9'h000, 0);
    chk("edge_ready0", r0, 1'b1);
    drive(0, 9'h000, 0, 9'h000, 0);
    chk("edge_start", {st, data}, {1'b1, 8'hAA});
    for (int k = 0; k < 8; k++) begin
      drive(0, 9'h000, 0, 9'h000, (k == 7));
      chk($sformatf("edge_wait%0d", k), {busy, terr}, 2'b10);
    end
    drive(0, 9'h000, 0, 9'h000, 0);
    chk("edge_no_terr", {busy, terr}, 2'b10);
    for (int k = 0; k < 3; k++) drive(0, 9'h000, 0, 9'h000, 0);
    drive(0, 9'h000, 0, 9'h000, 0);
    chk("edge_idle", {busy, terr}, 2'b00);

    // Genuine timeout: flag rises 8 cycles after WAIT entry and sticks
    drive(1, 9'h055, 0, 9'h000, 0);
    drive(0, 9'h000, 0, 9'h000, 0);
    chk("to_start", st, 1'b1);
    for (int k = 0; k < 8; k++) begin
      drive(0, 9'h000, 0, 9'h000, 0);
      chk($sformatf("to_wait%0d", k), {busy, terr}, 2'b10);
    end
    drive(0, 9'h000, 0, 9'h000, 0);
    chk("to_set", {busy, terr}, 2'b11);
    for (int k = 0; k < 3; k++) drive(0, 9'h000, 0, 9'h000, 0);
    drive(0, 9'h000, 0, 9'h000, 0);
    chk("to_idle", {busy, terr}, 2'b01);
    drive(0, 9'h000, 0, 9'h000, 0);
    chk("to_sticky", terr, 1'b1);

    // Reset mid-DLY with req1 pending
    drive(1, 9'h0F0, 0, 9'h000, 0);
    drive(0, 9'h000, 0, 9'h000, 0);
    drive(0, 9'h000, 0, 9'h000, 1);
    drive(0, 9'h000, 1, 9'h1C5, 0);
    chk("rst_pre", {17'd0, outs_a()}, {17'd0, E(0,0,0,8'hF0,0,1,0,1)});
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid", {17'd0, outs_a()}, {17'd0, E(0,0,0,8'h00,0,0,0,0)});
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_first", {17'd0, outs_a()}, {17'd0, E(0,1,0,8'h00,0,0,0,0)});
    drive(0, 9'h000, 0, 9'h000, 0);
    chk("rst_grant1", {17'd0, outs_a()}, {17'd0, E(0,0,1,8'hC5,1,1,1,0)});

    // POST_DELAY=0: done in first WAIT cycle, starts every third cycle
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      b_v0 = 1'b1; b_d0 = 9'h0C3; b_done = (i % 3 == 2);
      #1;
      chk($sformatf("pd0[%0d]", i), {b_r0, b_st, b_busy, b_gid, b_terr},
          {(i % 3 == 0), (i % 3 == 1), (i % 3 != 0), 1'b0, 1'b0});
    end
    chk("pd0_data", {b_rs, b_data}, {1'b0, 8'hC3});

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
